// File: rtl/uart_tx_mmio_if.sv
// CPU-side register bus for uart_tx_mmio: address, write data/strobe and
// combinational read data back to the CPU input mux.
interface uart_tx_mmio_if;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic [7:0]  rdata;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS/DIV_LO/DIV_HI registers,
// TX FIFO with sticky overflow, programmable bit period of DIV+1 clocks.
module uart_tx_mmio #(
    parameter logic [15:0] BASE_ADDR   = 16'hFF00,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_mmio_if.slave   bus,
    output logic            tx,
    output logic            irq
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, state_next;
    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               overflow;
    logic [15:0]        div;
    logic [15:0]        bit_cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shift;

    logic               sel;
    logic [1:0]         off;
    logic               full, empty;
    logic               push, pop, ovf_event;
    logic               wr_status, wr_div_lo, wr_div_hi;
    logic               bit_end;
    logic               busy;
    logic               tx_next;

    assign sel       = (bus.addr[15:2] == BASE_ADDR[15:2]);
    assign off       = bus.addr[1:0];
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign push      = bus.we & sel & (off == 2'd0) & ~full;
    assign ovf_event = bus.we & sel & (off == 2'd0) & full;
    assign wr_status = bus.we & sel & (off == 2'd1);
    assign wr_div_lo = bus.we & sel & (off == 2'd2);
    assign wr_div_hi = bus.we & sel & (off == 2'd3);
    assign bit_end   = (bit_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (!empty) state_next = START;
            START: if (bit_end) state_next = DATA;
            DATA:  if (bit_end && bit_idx == 3'd7) state_next = STOP;
            STOP:  if (bit_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pop     = 1'b0;
        tx_next = 1'b1;
        busy    = (state != IDLE);
        irq     = empty & (state == IDLE);
        unique case (state)
            IDLE:  pop = !empty;
            START: tx_next = 1'b0;
            DATA:  tx_next = shift[0];
            STOP:  tx_next = 1'b1;
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.wdata;
    end

    // tx is registered from the state, so the line trails the FSM by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            div      <= DEFAULT_DIV;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            tx <= tx_next;
            if (push) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (ovf_event)      overflow <= 1'b1;
            else if (wr_status) overflow <= 1'b0;
            if (wr_div_lo) div[7:0]  <= bus.wdata;
            if (wr_div_hi) div[15:8] <= bus.wdata;
            // Counter reloads from the live divisor at each bit start, so a
            // divisor write lands on the next bit boundary.
            if (pop) begin
                bit_cnt <= div;
                bit_idx <= '0;
                shift   <= mem[rd_ptr];
            end else if (busy) begin
                if (bit_end) begin
                    bit_cnt <= div;
                    if (state == DATA) begin
                        bit_idx <= bit_idx + 3'd1;
                        shift   <= {1'b0, shift[7:1]};
                    end
                end else begin
                    bit_cnt <= bit_cnt - 16'd1;
                end
            end
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (sel) begin
            unique case (off)
                2'd1:    bus.rdata = {4'b0000, overflow, busy, empty, full};
                2'd2:    bus.rdata = div[7:0];
                2'd3:    bus.rdata = div[15:8];
                default: bus.rdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: a line monitor decodes frames against a
// scoreboard of written bytes; directed steps check timing, status and reset.
module tb_uart_tx_mmio;
    localparam logic [15:0] BASE    = 16'hFF00;
    localparam logic [15:0] A_DATA  = BASE;
    localparam logic [15:0] A_STAT  = BASE + 16'd1;
    localparam logic [15:0] A_DIVLO = BASE + 16'd2;
    localparam logic [15:0] A_DIVHI = BASE + 16'd3;

    logic clk = 1'b0;
    logic rst;
    logic tx, irq;

    uart_tx_mmio_if bus();

    uart_tx_mmio #(
        .BASE_ADDR(16'hFF00),
        .FIFO_DEPTH(8),
        .DEFAULT_DIV(16'd433)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .tx(tx),
        .irq(irq)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  sb_q[$];
    longint      start_t[$];
    bit          mon_en = 1'b0;
    int          mon_div = 0;
    int          frames_done = 0;
    logic        txlog [0:16383];
    int          cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = 1'b1;
        @(posedge clk);
        #1 bus.we = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        bus.addr = a;
        #1 d = bus.rdata;
    endtask

    task automatic push_data(input logic [7:0] d);
        wr(A_DATA, d);
        if (mon_en) sb_q.push_back(d);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input string tag, input int target, input int budget);
        int k;
        k = 0;
        while (frames_done < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk(tag, 32'(frames_done >= target), 32'd1);
    endtask

    // Per-cycle line log, sampled away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc < 16384) txlog[cyc] = tx;
            cyc++;
        end
    end

    // Frame monitor: every cycle of each bit must hold the same level.
    initial begin
        logic       prev;
        logic [9:0] bits;
        logic       bad;
        int         p;
        logic [7:0] e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && prev === 1'b1 && tx === 1'b0) begin
                p = mon_div + 1;
                bad = 1'b0;
                bits = '0;
                start_t.push_back($time);
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < p; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (c == 0) bits[b] = tx;
                        else if (tx !== bits[b]) bad = 1'b1;
                    end
                end
                chk("frame_shape", {29'd0, bad, bits[9], bits[0]}, 32'b010);
                chk("sb_pending", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("sb_data", {24'd0, bits[8:1]}, {24'd0, e});
                end
                frames_done++;
            end
            prev = tx;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  r;
        logic [12:0] seq;
        int          c0, nf, idx, n, zeros;
        int          runs[10];
        logic        v;

        rst = 1'b1;
        bus.addr = '0;
        bus.wdata = '0;
        bus.we = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;

        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_irq", 32'(irq), 32'd1);
        rd(A_STAT, r);  chk("rst_status", 32'(r), 32'h02);
        rd(A_DIVLO, r); chk("rst_div_lo", 32'(r), 32'hB1);
        rd(A_DIVHI, r); chk("rst_div_hi", 32'(r), 32'h01);
        rd(A_DATA, r);  chk("data_reads_zero", 32'(r), 32'h00);

        // DIV=0, single byte: exact line sequence from the write edge.
        wr(A_DIVLO, 8'h00);
        wr(A_DIVHI, 8'h00);
        mon_div = 0;
        mon_en = 1'b1;
        nf = frames_done + 1;
        push_data(8'hA5);
        c0 = cyc;
        chk("queued_irq", 32'(irq), 32'd0);
        rd(A_STAT, r); chk("queued_status", 32'(r), 32'h00);
        cycles(1);
        rd(A_STAT, r); chk("busy_status", 32'(r), 32'h06);
        wait_frames("a5_frame_timeout", nf, 100);
        cycles(3);
        for (int i = 0; i < 13; i++) seq[i] = txlog[c0 + i];
        chk("a5_line_seq", 32'(seq), 32'({2'b11, 8'hA5, 3'b011}));
        rd(A_STAT, r); chk("a5_done_status", 32'(r), 32'h02);
        chk("a5_done_irq", 32'(irq), 32'd1);

        // DIV=3, back-to-back bytes: 40-clock frames with one idle clock.
        wr(A_DIVLO, 8'h03);
        mon_div = 3;
        start_t.delete();
        nf = frames_done + 2;
        push_data(8'h00);
        push_data(8'hFF);
        wait_frames("b2b_timeout", nf, 400);
        chk("b2b_gap", 32'(start_t.size() >= 2 ? (start_t[1] - start_t[0]) / 10 : 0), 32'd41);
        cycles(6);
        rd(A_STAT, r); chk("b2b_empty", 32'(r), 32'h02);

        // DIV=2, mixed patterns through the scoreboard.
        wr(A_DIVLO, 8'h02);
        mon_div = 2;
        nf = frames_done + 5;
        push_data(8'h5A);
        push_data(8'h81);
        push_data(8'h3C);
        push_data(8'($urandom_range(0, 255)));
        push_data(8'($urandom_range(0, 255)));
        wait_frames("mix_timeout", nf, 400);
        cycles(4);
        mon_en = 1'b0;

        // Fill at default divisor: first byte is in flight, then 8 fill and 1 drops.
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        push_data(8'h11);
        cycles(2);
        rd(A_STAT, r); chk("fill_busy", 32'(r), 32'h06);
        for (int i = 0; i < 9; i++) push_data(8'(8'h20 + i));
        rd(A_STAT, r); chk("fill_overflow", 32'(r), 32'h0D);
        chk("fill_irq", 32'(irq), 32'd0);
        wr(A_STAT, 8'hFF);
        rd(A_STAT, r); chk("ovf_cleared", 32'(r), 32'h05);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;

        // DIV=1 frame of 8'h55, divisor raised to 7 during data bit 3.
        wr(A_DIVLO, 8'h01);
        wr(A_DIVHI, 8'h00);
        push_data(8'h55);
        c0 = cyc;
        repeat (9) @(posedge clk);
        wr(A_DIVLO, 8'h07);
        cycles(60);
        idx = c0;
        while (idx < c0 + 20 && txlog[idx] !== 1'b0) idx++;
        for (int k = 0; k < 10; k++) begin
            v = txlog[idx];
            n = 0;
            while (txlog[idx] === v && n < 40) begin
                n++;
                idx++;
            end
            runs[k] = n;
        end
        chk("div_start_len", 32'(runs[0]), 32'd2);
        chk("div_bit3_len", 32'(runs[4]), 32'd2);
        chk("div_bit4_len", 32'(runs[5]), 32'd8);
        chk("div_bit7_len", 32'(runs[8]), 32'd8);

        // Reset during data bit 5 with a simultaneous DIV_LO write.
        wr(A_DIVLO, 8'h01);
        push_data(8'h3C);
        repeat (13) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.addr = A_DIVLO;
        bus.wdata = 8'h55;
        bus.we = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.we = 1'b0;
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_irq", 32'(irq), 32'd1);
        rd(A_STAT, r);  chk("abort_status", 32'(r), 32'h02);
        rd(A_DIVLO, r); chk("abort_div_lo", 32'(r), 32'hB1);
        rd(A_DIVHI, r); chk("abort_div_hi", 32'(r), 32'h01);
        c0 = cyc;
        cycles(40);
        zeros = 0;
        for (int i = 0; i < 40; i++) if (txlog[c0 + i] !== 1'b1) zeros++;
        chk("abort_line_idle", 32'(zeros), 32'd0);

        // Addresses just outside the block.
        rd(BASE + 16'd4, r); chk("oob_hi_read", 32'(r), 32'h00);
        rd(BASE - 16'd1, r); chk("oob_lo_read", 32'(r), 32'h00);
        wr(BASE + 16'd4, 8'h77);
        wr(BASE - 16'd1, 8'h12);
        wr(BASE + 16'd6, 8'h09);
        cycles(3);
        rd(A_STAT, r);  chk("oob_status", 32'(r), 32'h02);
        rd(A_DIVLO, r); chk("oob_div_lo", 32'(r), 32'hB1);
        rd(A_DIVHI, r); chk("oob_div_hi", 32'(r), 32'h01);
        chk("oob_tx", 32'(tx), 32'd1);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
